// File: rtl/qsram_pkg.sv
// Shared types and default sizing for the QSRAM access scheduler and its refresh timer.
package qsram_pkg;

    localparam int DEFAULT_ADDR_W           = 4;
    localparam int DEFAULT_REFRESH_INTERVAL = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        READ,
        WRITE,
        REFRESH
    } op_e;

endpackage

// File: rtl/qsram_refresh_timer.sv
// Refresh demand generator: countdown timer, pending flag, refresh row pointer and a
// sticky overrun flag raised when a demand arrives while the previous one is still waiting.
module qsram_refresh_timer
    import qsram_pkg::*;
#(
    parameter int ADDR_W           = DEFAULT_ADDR_W,
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              grant_i,
    input  logic              row_inc_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] row_o,
    output logic              overrun_o
);

    localparam int                 TIMER_W = $clog2(REFRESH_INTERVAL);
    localparam logic [TIMER_W-1:0] RELOAD  = TIMER_W'(REFRESH_INTERVAL - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pending_q, pending_d;
    logic [ADDR_W-1:0]  row_q, row_d;
    logic               overrun_q, overrun_d;
    logic               expire;

    assign expire = (timer_q == '0);

    always_comb begin
        timer_d   = expire ? RELOAD : timer_q - TIMER_W'(1);
        pending_d = pending_q;
        if (grant_i) begin
            pending_d = 1'b0;
        end
        // A fresh expiry wins over a grant in the same cycle.
        if (expire) begin
            pending_d = 1'b1;
        end
        row_d     = row_inc_i ? row_q + ADDR_W'(1) : row_q;
        overrun_d = overrun_q | (expire & pending_q & ~grant_i);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q   <= RELOAD;
            pending_q <= 1'b0;
            row_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_o = pending_q;
    assign row_o     = row_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/qsram_access_scheduler.sv
// Single-port cell-array scheduler: arbitrates refresh, read and write requests and runs
// each granted access through a fixed SETUP/STROBE/HOLD sequence.
module qsram_access_scheduler
    import qsram_pkg::*;
#(
    parameter int ADDR_W           = DEFAULT_ADDR_W,
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReadReq,
    input  logic              WriteReq,
    input  logic [ADDR_W-1:0] ReadAddr,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic              WriteData,
    output logic              ReadAck,
    output logic              WriteAck,
    output logic              ReadData,
    output logic [ADDR_W-1:0] CellAddr,
    output logic              CellData,
    input  logic              CellOutput,
    output logic              ReadEdge,
    output logic              WriteEdge,
    output logic              RefreshEdge,
    output logic              RefreshOverrun
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              data_q, data_d;
    logic              read_data_q, read_data_d;
    logic              favour_read_q, favour_read_d;

    logic              refresh_pending;
    logic [ADDR_W-1:0] refresh_row;
    logic              refresh_grant;
    logic              refresh_row_inc;

    assign refresh_row_inc = (state_q == HOLD) && (op_q == REFRESH);

    qsram_refresh_timer #(
        .ADDR_W           (ADDR_W),
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk_i     (Clock),
        .reset_i   (Reset),
        .grant_i   (refresh_grant),
        .row_inc_i (refresh_row_inc),
        .pending_o (refresh_pending),
        .row_o     (refresh_row),
        .overrun_o (RefreshOverrun)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        read_data_d   = read_data_q;
        favour_read_d = favour_read_q;
        refresh_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (refresh_pending) begin
                    state_d       = SETUP;
                    op_d          = REFRESH;
                    addr_d        = refresh_row;
                    data_d        = 1'b0;
                    refresh_grant = 1'b1;
                end else if (ReadReq && (!WriteReq || favour_read_q)) begin
                    state_d       = SETUP;
                    op_d          = READ;
                    addr_d        = ReadAddr;
                    data_d        = 1'b0;
                    favour_read_d = 1'b0;
                end else if (WriteReq) begin
                    state_d       = SETUP;
                    op_d          = WRITE;
                    addr_d        = WriteAddr;
                    data_d        = WriteData;
                    favour_read_d = 1'b1;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                state_d = HOLD;
                if (op_q == READ) begin
                    read_data_d = CellOutput;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            op_q          <= READ;
            addr_q        <= '0;
            data_q        <= 1'b0;
            read_data_q   <= 1'b0;
            favour_read_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            read_data_q   <= read_data_d;
            favour_read_q <= favour_read_d;
        end
    end

    // Cell-side drive is held for the whole access and parked at zero in IDLE.
    assign CellAddr    = (state_q != IDLE) ? addr_q : '0;
    assign CellData    = (state_q != IDLE) && data_q;
    assign ReadEdge    = (state_q == STROBE) && (op_q == READ);
    assign WriteEdge   = (state_q == STROBE) && (op_q == WRITE);
    assign RefreshEdge = (state_q == STROBE) && (op_q == REFRESH);
    assign ReadAck     = (state_q == HOLD) && (op_q == READ);
    assign WriteAck    = (state_q == HOLD) && (op_q == WRITE);
    assign ReadData    = ReadAck && read_data_q;

endmodule

// File: tb/tb_qsram_access_scheduler.sv
// Scoreboard bench: directed scenarios push hand-timed expected events (cycle counted from
// the last reset edge); a negedge monitor pops and compares every strobe/ack the DUT shows.
module tb_qsram_access_scheduler;

    localparam int ADDR_W = 4;
    localparam int RI     = 16;

    localparam int EV_RD_EDGE = 0;
    localparam int EV_WR_EDGE = 1;
    localparam int EV_RF_EDGE = 2;
    localparam int EV_RD_ACK  = 3;
    localparam int EV_WR_ACK  = 4;

    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
        bit chk_addr;
        bit chk_data;
    } exp_t;

    logic              Clock;
    logic              Reset;
    logic              ReadReq, WriteReq;
    logic [ADDR_W-1:0] ReadAddr, WriteAddr;
    logic              WriteData;
    logic              ReadAck, WriteAck, ReadData;
    logic [ADDR_W-1:0] CellAddr;
    logic              CellData, CellOutput;
    logic              ReadEdge, WriteEdge, RefreshEdge;
    logic              RefreshOverrun;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    qsram_access_scheduler #(
        .ADDR_W           (ADDR_W),
        .REFRESH_INTERVAL (RI)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ReadReq        (ReadReq),
        .WriteReq       (WriteReq),
        .ReadAddr       (ReadAddr),
        .WriteAddr      (WriteAddr),
        .WriteData      (WriteData),
        .ReadAck        (ReadAck),
        .WriteAck       (WriteAck),
        .ReadData       (ReadData),
        .CellAddr       (CellAddr),
        .CellData       (CellData),
        .CellOutput     (CellOutput),
        .ReadEdge       (ReadEdge),
        .WriteEdge      (WriteEdge),
        .RefreshEdge    (RefreshEdge),
        .RefreshOverrun (RefreshOverrun)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Cycle 0 is the cycle right after a reset edge.
    always @(posedge Clock) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic fail_now(input string name, input int val);
        n_checks++;
        $display("FAIL %s at cycle %0d: value %0d", name, cyc, val);
    endtask

    task automatic expect_ev(input int kind, input int c, input int addr, input int data,
                             input bit ca, input bit cd);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = addr; e.data = data;
        e.chk_addr = ca; e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    // Grant in IDLE cycle t: strobe at t+2, ack at t+3.
    task automatic exp_read(input int t, input int addr, input int rdata);
        expect_ev(EV_RD_EDGE, t + 2, addr, 0, 1'b1, 1'b0);
        expect_ev(EV_RD_ACK,  t + 3, 0, rdata, 1'b0, 1'b1);
    endtask

    task automatic exp_write(input int t, input int addr, input int wdata);
        expect_ev(EV_WR_EDGE, t + 2, addr, wdata, 1'b1, 1'b1);
        expect_ev(EV_WR_ACK,  t + 3, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic exp_refresh(input int t, input int row);
        expect_ev(EV_RF_EDGE, t + 2, row, 0, 1'b1, 1'b0);
    endtask

    always @(negedge Clock) begin : monitor
        int   n_obs;
        int   kind;
        exp_t e;
        n_obs = int'(ReadEdge) + int'(WriteEdge) + int'(RefreshEdge)
              + int'(ReadAck) + int'(WriteAck);
        kind  = ReadEdge  ? EV_RD_EDGE :
                WriteEdge ? EV_WR_EDGE :
                RefreshEdge ? EV_RF_EDGE :
                ReadAck   ? EV_RD_ACK  : EV_WR_ACK;
        if (n_obs > 1) begin
            fail_now("several_outputs_high", n_obs);
        end else if (n_obs == 1) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_event_kind", kind);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (e.chk_addr) check("event_addr", CellAddr, e.addr);
                if (e.chk_data) check("event_data", (e.kind == EV_RD_ACK) ? ReadData : CellData, e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            fail_now("missing_event_kind", e.kind);
        end
    end

    task automatic goto(input int n);
        int guard = 0;
        do begin
            @(negedge Clock);
            guard++;
        end while (cyc != n && guard < 1000);
        if (cyc != n) begin
            $display("FAIL goto: cycle %0d never reached", n);
            $fatal(1);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check(name, {ReadAck, WriteAck, ReadData, ReadEdge, WriteEdge, RefreshEdge,
                     RefreshOverrun, CellData, CellAddr}, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge of cycle 0 with Reset released.
    task automatic pulse_reset();
        Reset = 1'b1;
        @(negedge Clock);
        check_idle_zero("reset_state");
        Reset = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        pulse_reset();
    endtask

    initial begin
        Reset = 1'b1; ReadReq = 1'b0; WriteReq = 1'b0;
        ReadAddr = '0; WriteAddr = '0; WriteData = 1'b0; CellOutput = 1'b0;

        // Single write; address/data changed after grant must not leak through.
        do_reset();
        WriteReq = 1'b1; WriteAddr = 4'd5; WriteData = 1'b1;
        exp_write(0, 5, 1);
        goto(1); WriteAddr = 4'd9; WriteData = 1'b0;
        goto(3); WriteReq = 1'b0;
        goto(5);
        check_idle_zero("idle_after_write");
        check("drained_write", exp_q.size(), 0);

        // Two reads: CellOutput captured only at the end of STROBE.
        do_reset();
        ReadReq = 1'b1; ReadAddr = 4'd5;
        exp_read(0, 5, 1);
        goto(2); CellOutput = 1'b1;
        goto(3); CellOutput = 1'b0; ReadReq = 1'b0;
        goto(4); ReadReq = 1'b1; ReadAddr = 4'd10;
        exp_read(4, 10, 0);
        goto(5); CellOutput = 1'b1; ReadAddr = 4'd1;
        goto(6); CellOutput = 1'b0;
        goto(7); CellOutput = 1'b1; ReadReq = 1'b0;
        goto(9); CellOutput = 1'b0;
        check("drained_read", exp_q.size(), 0);

        // Both held: R,W alternate; refresh preempts at IDLE cycles 16, 32, 48.
        do_reset();
        ReadReq = 1'b1; ReadAddr = 4'd3; WriteReq = 1'b1; WriteAddr = 4'd12; WriteData = 1'b1;
        CellOutput = 1'b1;
        exp_read(0, 3, 1);   exp_write(4, 12, 1);  exp_read(8, 3, 1);  exp_write(12, 12, 1);
        exp_refresh(16, 0);  exp_read(20, 3, 1);   exp_write(24, 12, 1); exp_read(28, 3, 1);
        exp_refresh(32, 1);  exp_write(36, 12, 1); exp_read(40, 3, 1);
        exp_refresh(48, 2);
        goto(43); ReadReq = 1'b0; WriteReq = 1'b0; CellOutput = 1'b0;
        goto(53);
        check_idle_zero("idle_after_rr");
        check("drained_rr", exp_q.size(), 0);

        // Idle bus: 17 refreshes walk rows 0..15 then wrap to 0.
        do_reset();
        for (int k = 0; k < 17; k++) exp_refresh(RI * (k + 1), k % 16);
        goto(8);
        check_idle_zero("idle_parked");
        goto(276);
        check_idle_zero("idle_after_refresh_sweep");
        check("drained_refresh", exp_q.size(), 0);

        // Reset during STROBE of a write aborts it; the held request is served again.
        do_reset();
        WriteReq = 1'b1; WriteAddr = 4'd7; WriteData = 1'b1;
        expect_ev(EV_WR_EDGE, 2, 7, 1, 1'b1, 1'b1);
        goto(2);
        pulse_reset();
        exp_write(0, 7, 1);
        goto(3); WriteReq = 1'b0;
        goto(5);
        check("drained_abort", exp_q.size(), 0);

        // Periodic resets under a held read stream, then a long read stream with refresh.
        do_reset();
        ReadReq = 1'b1; ReadAddr = 4'd2; CellOutput = 1'b0;
        for (int p = 0; p < 3; p++) begin
            exp_read(0, 2, 0); exp_read(4, 2, 0); exp_read(8, 2, 0);
            goto(11);
            pulse_reset();
        end
        for (int t = 0; t <= 44; t += 4) begin
            if (t == 16)      exp_refresh(16, 0);
            else if (t == 32) exp_refresh(32, 1);
            else              exp_read(t, 2, 0);
        end
        exp_refresh(48, 2);
        goto(47); ReadReq = 1'b0;
        goto(53);
        check_idle_zero("idle_after_read_stream");
        check("drained_read_stream", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
